// File: rtl/soc_led_pio_if.sv
// -----------------------------------------------------------------------------
// soc_led_pio_if
//
// Avalon-MM slave bus bundle for the LED output port.
//
// Signals:
//   address    [1:0]  word address (DATA / BLINK_MASK / OUTSET / OUTCLEAR)
//   chipselect        slave selected
//   write_n           active-low write strobe; chipselect && write_n is a read
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (read latency 1)
//
// Modports:
//   master  drives the request, receives readdata (Nios II side / testbench)
//   slave   receives the request, drives readdata (soc_led_pio)
// -----------------------------------------------------------------------------
interface soc_led_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_led_pio.sv
// -----------------------------------------------------------------------------
// soc_led_pio
//
// Avalon-MM output parallel port driving board LEDs. Provides a read/write
// DATA register, atomic bit-set (OUTSET) and bit-clear (OUTCLEAR) strobes and,
// when SOC_LED_PIO_BLINK_EN is defined, a blink mask that gates selected
// outputs off during the "off" half of a free-running blink period.
//
// Configuration macro:
//   SOC_LED_PIO_BLINK_EN  defined   -> blink mask, counter and phase built
//                         undefined -> BLINK_MASK reads 0, writes ignored,
//                                      out_port simply follows DATA
//
// Parameters:
//   WIDTH        number of output bits (1..32)
//   RESET_VALUE  DATA / out_port value after reset
//   BLINK_DIV    clock cycles per blink half-period (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   bus       Avalon-MM slave (soc_led_pio_if.slave)
//   out_port  registered LED drive
// -----------------------------------------------------------------------------
module soc_led_pio #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      BLINK_DIV   = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    soc_led_pio_if.slave        bus,
    output logic [WIDTH-1:0]    out_port
);

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_MASK     = 2'd1,
        ADDR_OUTSET   = 2'd2,
        ADDR_OUTCLEAR = 2'd3
    } reg_addr_e;

    reg_addr_e        addr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] mask_rd;    // mask as seen by the read mux
    logic [WIDTH-1:0] blink_off;  // bits forced low this cycle

    // Bits of writedata above WIDTH are architecturally ignored.
    logic unused_writedata;
    assign unused_writedata = ^bus.writedata;

    assign addr  = reg_addr_e'(bus.address);
    assign wr_en = bus.chipselect && !bus.write_n;
    assign rd_en = bus.chipselect &&  bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    // ---------------------------------------------------------------- DATA
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves data_d unassigned and no latch is inferred.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (addr)
                ADDR_DATA:     data_d = wdata;
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       data_d = data_q;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef SOC_LED_PIO_BLINK_EN
    // ---------------------------------------------------------------- blink
    localparam int unsigned     CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;    // 1 = on half, masked bits follow DATA

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            if (wr_en && addr == ADDR_MASK) begin
                mask_q <= wdata;
            end
            // Free-running regardless of mask writes; phase flips on wrap.
            if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign mask_rd   = mask_q;
    assign blink_off = mask_q & {WIDTH{~phase_q}};
`else
    assign mask_rd   = '0;
    assign blink_off = '0;
`endif

    // ---------------------------------------------------------------- output
    // Registered from the DATA register, so it lags register updates by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= RESET_VALUE;
        end else begin
            out_port <= data_q & ~blink_off;
        end
    end

    // ---------------------------------------------------------------- read
    // DATA reads the register, not out_port; idle cycles return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd_en) begin
            case (addr)
                ADDR_DATA: bus.readdata <= 32'(data_q);
                ADDR_MASK: bus.readdata <= 32'(mask_rd);
                default:   bus.readdata <= '0;
            endcase
        end else begin
            bus.readdata <= '0;
        end
    end

endmodule

// File: tb/tb_soc_led_pio.sv
// -----------------------------------------------------------------------------
// tb_soc_led_pio
//
// Self-checking bench for soc_led_pio (WIDTH=8, RESET_VALUE=8'hA5,
// BLINK_DIV=4). A cycle-level reference model derives the blink phase from
// the number of clock edges since reset and applies the register rules
// directly; out_port and readdata are compared against it every cycle.
// Directed scenarios add fixed expected values, followed by random traffic.
// Blink expectations follow SOC_LED_PIO_BLINK_EN.
// -----------------------------------------------------------------------------
module tb_soc_led_pio;

    localparam int unsigned WIDTH     = 8;
    localparam logic [7:0]  RST_VAL   = 8'hA5;
    localparam int unsigned BLINK_DIV = 4;
`ifdef SOC_LED_PIO_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] out_port;

    soc_led_pio_if bus_if ();

    soc_led_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RST_VAL),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [7:0]  m_out;
    logic [31:0] m_rd;
    int          m_edges;   // clock edges since the last reset edge

    function automatic bit model_phase_on();
        return ((m_edges / BLINK_DIV) % 2) == 0;
    endfunction

    task automatic model_edge();
        logic [7:0] wd;
        wd = bus_if.writedata[7:0];
        if (reset) begin
            m_data  = RST_VAL;
            m_mask  = 8'h00;
            m_out   = RST_VAL;
            m_rd    = 32'h0;
            m_edges = 0;
        end else begin
            m_out = (BLINK && !model_phase_on()) ? (m_data & ~m_mask) : m_data;
            if (bus_if.chipselect && bus_if.write_n) begin
                case (bus_if.address)
                    2'd0:    m_rd = {24'h0, m_data};
                    2'd1:    m_rd = {24'h0, m_mask};
                    default: m_rd = 32'h0;
                endcase
            end else begin
                m_rd = 32'h0;
            end
            if (bus_if.chipselect && !bus_if.write_n) begin
                case (bus_if.address)
                    2'd0:    m_data = wd;
                    2'd1:    if (BLINK) m_mask = wd;
                    2'd2:    m_data = m_data | wd;
                    default: m_data = m_data & ~wd;
                endcase
            end
            m_edges++;
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out_port", 32'(out_port), 32'(m_out));
        check("readdata", bus_if.readdata, m_rd);
    endtask

    task automatic acc(input bit cs, input bit wn, input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.address    = a;
        bus_if.writedata  = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) acc(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int hi_cnt;
        int low_bad;

        reset = 1'b1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = 32'h0;

        // 1. reset values
        idle(2);
        reset = 1'b0;
        check("rst_out", 32'(out_port), 32'h0000_00A5);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("rst_rd_data", bus_if.readdata, 32'h0000_00A5);
        acc(1'b1, 1'b1, 2'd1, 32'h0);
        check("rst_rd_mask", bus_if.readdata, 32'h0);

        // 2. set / clear / readback, out_port lags by one cycle
        acc(1'b1, 1'b0, 2'd0, 32'hFFFF_FF00);
        check("lag_data", 32'(out_port), 32'h0000_00A5);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("rd_data", bus_if.readdata, 32'h0000_0000);
        check("out_data", 32'(out_port), 32'h0000_0000);
        acc(1'b1, 1'b0, 2'd2, 32'h0000_000F);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("rd_outset", bus_if.readdata, 32'h0000_000F);
        check("out_outset", 32'(out_port), 32'h0000_000F);
        acc(1'b1, 1'b0, 2'd3, 32'h0000_0003);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("rd_outclear", bus_if.readdata, 32'h0000_000C);
        check("out_outclear", 32'(out_port), 32'h0000_000C);

        // 3. blink: any 16 consecutive cycles span two full periods
        acc(1'b1, 1'b0, 2'd0, 32'h0000_00FF);
        acc(1'b1, 1'b0, 2'd1, 32'h0000_00F0);
        idle(1);
        hi_cnt  = 0;
        low_bad = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (out_port == 8'hFF) hi_cnt++;
            if (out_port[3:0] != 4'hF) low_bad++;
        end
        check("blink_duty", 32'(hi_cnt), BLINK ? 32'd8 : 32'd16);
        check("blink_low_nibble", 32'(low_bad), 32'd0);

        // 4. reset during the off phase, with a coincident write discarded
        for (int i = 0; i < 2 * BLINK_DIV && (!BLINK || model_phase_on()); i++) idle(1);
        reset = 1'b1;
        acc(1'b1, 1'b0, 2'd0, 32'h0000_0011);
        reset = 1'b0;
        check("midrst_out", 32'(out_port), 32'h0000_00A5);
        acc(1'b1, 1'b1, 2'd1, 32'h0);
        check("midrst_mask", bus_if.readdata, 32'h0);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("midrst_data", bus_if.readdata, 32'h0000_00A5);
        acc(1'b1, 1'b0, 2'd1, 32'h0000_000F);
        idle(3 * BLINK_DIV);

        // 5. ignored access, strobe reads, back-to-back reads
        acc(1'b1, 1'b0, 2'd1, 32'h0);
        acc(1'b1, 1'b0, 2'd0, 32'h0000_005A);
        acc(1'b0, 1'b0, 2'd0, 32'h0000_0077);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("nocs_data", bus_if.readdata, 32'h0000_005A);
        acc(1'b1, 1'b0, 2'd2, 32'hFFFF_FF01);
        acc(1'b1, 1'b1, 2'd2, 32'h0);
        check("rd_outset_zero", bus_if.readdata, 32'h0);
        acc(1'b1, 1'b1, 2'd3, 32'h0);
        check("rd_outclear_zero", bus_if.readdata, 32'h0);
        acc(1'b1, 1'b1, 2'd0, 32'h0);
        check("b2b_rd_data", bus_if.readdata, 32'h0000_005B);
        idle(1);
        check("idle_rd_zero", bus_if.readdata, 32'h0);

`ifndef SOC_LED_PIO_BLINK_EN
        // 6. blink disabled: mask is not stored, output steady
        acc(1'b1, 1'b0, 2'd1, 32'h0000_00FF);
        acc(1'b1, 1'b0, 2'd0, 32'h0000_003C);
        idle(1);
        low_bad = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (out_port != 8'h3C) low_bad++;
        end
        check("noblink_steady", 32'(low_bad), 32'd0);
        acc(1'b1, 1'b1, 2'd1, 32'h0);
        check("noblink_mask_rd", bus_if.readdata, 32'h0);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            acc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), $urandom);
        end
        reset = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soc_led_pio.md
# soc_led_pio

Avalon-MM output parallel port driving board LEDs from the Nios II data master; the write-side counterpart of the SoC push-button input port. It has a read/write data register, atomic bit-set and bit-clear registers, and an optional hardware blink mask. The blink mask toggles selected outputs at a programmable rate without CPU involvement. The block sits on the Qsys interconnect as an Avalon-MM slave, and `out_port` is exported to top-level LED pins.

## Interface
- `WIDTH`, default 8: number of output bits (1..32).
- `RESET_VALUE`, default 0: value of the data register and `out_port` after reset.
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period (≥1).
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `address`, input, 2: word address.
  - 0 = DATA
  - 1 = BLINK_MASK
  - 2 = OUTSET
  - 3 = OUTCLEAR
- `chipselect`, input, 1: slave selected.
- `write_n`, input, 1: active-low write strobe; a read is `chipselect && write_n`.
- `writedata`, input, 32: write data; only bits [WIDTH-1:0] are used.
- `readdata`, output, 32: registered read data, zero-extended above WIDTH.
- `out_port`, output, WIDTH: registered LED drive.

## Operation
- **Registers:**
  - `data[WIDTH-1:0]`
  - `mask[WIDTH-1:0]`
  - blink counter `cnt`, width ceil(log2(BLINK_DIV)) with a minimum of 1
  - `phase` bit, 1 = on
- **Write** (`chipselect && !write_n`):
  - addr 0: `data <= writedata[WIDTH-1:0]`
  - addr 1: `mask <= writedata[WIDTH-1:0]`
  - addr 2: `data <= data | writedata[WIDTH-1:0]`
  - addr 3: `data <= data & ~writedata[WIDTH-1:0]`
- **No access:** writes with `chipselect=0` are ignored. Upper writedata bits are ignored.
- **Read:**
  - addr 0 returns `data`, not `out_port`.
  - addr 1 returns `mask`.
  - addrs 2 and 3 return 0.
  - When no read is in progress, `readdata` holds 0.
- **Blink counter:**
  - Free-running from 0 to BLINK_DIV-1.
  - At BLINK_DIV-1 it wraps to 0 and `phase` toggles.
  - With BLINK_DIV=1, `phase` toggles every cycle.
  - Writing `mask` neither resets `cnt` nor changes `phase`.
- **Output:** `out_port <= data & ~(mask & {WIDTH{~phase}})`. Masked bits follow `data` while `phase=1` and are forced to 0 while `phase=0`. Unmasked bits always follow `data`.
- **Reset:** synchronous, highest priority, and overrides a write in the same cycle. Values after reset:
  - `data=RESET_VALUE`, `mask=0`
  - `cnt=0`, `phase=1`
  - `readdata=0`, `out_port=RESET_VALUE`
  - An asserted reset mid-blink returns `phase` to 1 and restarts the half-period.

## Timing
- **Write latency:** a write sampled at edge N updates the register at N. `out_port` reflects the change at edge N+1, i.e. 1 cycle after the register.
- **Read latency:** 1 cycle. A read sampled at edge N presents `readdata` after edge N, valid in cycle N+1. This matches Qsys `readLatency=1`.
- **Back-to-back access:** a read in the cycle after a write returns the updated value. Reads and writes may alternate every cycle with no wait states, and there is no `waitrequest`.
- **Blink/write coincidence:** if `phase` toggles in the same edge as a `data` or `mask` write, both take effect at that edge. `out_port` uses the new values plus the new `phase` at the next edge.
- **Blink period:** `out_port` transitions on masked bits occur every BLINK_DIV cycles, with a duty cycle of exactly 50%.

## Configuration
- Macro: `SOC_LED_PIO_BLINK_EN`.
- **Defined:** the blink mask, counter and `phase` are implemented as described above.
- **Undefined:**
  - No counter, `phase` or `mask` storage is instantiated.
  - Writes to addr 1 are ignored and reads of addr 1 return 0.
  - `out_port <= data` (still registered, 1 cycle after the register).
  - BLINK_DIV is unused.

## Test plan
All scenarios use WIDTH=8, RESET_VALUE=8'hA5, BLINK_DIV=4 and the macro defined, unless stated.

1. **Reset values:** hold `reset` for 2 cycles, then release -> `out_port=8'hA5`; read addr 0 -> `readdata=32'h000000A5`; read addr 1 -> 0.
2. **Set, clear and readback:**
   - Write DATA=`32'hFFFF_FF00`, then OUTSET=`8'h0F`, then OUTCLEAR=`8'h03` on consecutive cycles.
   - Required: `data` reads 8'h00, then 8'h0F, then 8'h0C.
   - Required: `out_port` lags each update by one cycle.
   - Required: `readdata[31:8]=0`.
3. **Blink:** write DATA=`8'hFF`, MASK=`8'hF0` -> `out_port` alternates 8'hFF / 8'h0F every 4 cycles with a 50% duty cycle; the low nibble stays constant.
4. **Reset mid-blink:** assert `reset` while `phase=0` -> after release, `out_port=8'hA5`, `mask=0` and the counter restarts. A write coincident with `reset` is discarded.
5. **Ignored access:** issue a write with `chipselect=0`, and a write to OUTSET followed by a read of OUTSET/OUTCLEAR -> no register change from the `chipselect=0` write; OUTSET/OUTCLEAR read 0; 1-cycle read latency holds on back-to-back reads.
6. **Macro undefined:** write MASK=`8'hFF`, DATA=`8'h3C` -> MASK reads 0 and `out_port` holds 8'h3C steady for 20 cycles.
